bomb_controller: RTL and testbench
==================================

BOMB_CONTROLLER -- requirements
Module: bomb_controller

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of concurrently live bombs.
REQ-002 SHALL have parameter FUSE_FRAMES, default 120, frames from placement to detonation.
REQ-003 SHALL have parameter FLAME_FRAMES, default 30, frames a flame stays lit.
REQ-004 SHALL have parameter FLAME_RANGE, default 2, cells of flame reach per direction.
REQ-005 SHALL have port Frame_Clk, input, 1, frame clock; Reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port Bomb_Index_1, input, 32, player-1 placement request (cell index; 0 = none).
REQ-007 SHALL have port Bomb_Index_2, input, 32, player-2 placement request (cell index; 0 = none).
REQ-008 SHALL have ports Wall_Map and Tree_Map, input, 144 each, blocking cells (bit = row*12+col).
REQ-009 SHALL have ports Bomb_Map and Flame_Map, output, 144 each, cells holding a fused bomb and cells on fire.
REQ-010 SHALL have port Tree_Clear, output, 144, one-frame pulse marking trees destroyed this frame.
REQ-011 SHALL have port Slot_Busy, output, NUM_SLOTS, slot occupancy.

Function
REQ-012 Each slot SHALL run FSM IDLE -> FUSE -> FLAME -> IDLE, holding cell index (8 bits) and a frame counter.
REQ-013 A request SHALL be valid only if index is 1..143, its cell is not walled, and no slot already holds that index.
REQ-014 A valid request SHALL load the lowest-numbered IDLE slot, state FUSE, counter 0; Bomb_Map bit set from the next edge.
REQ-015 Same-cycle requests: Bomb_Index_1 SHALL be served first; an identical cell from Bomb_Index_2 SHALL be dropped.
REQ-016 Requests with no free slot SHALL be dropped silently; no queueing.
REQ-017 FUSE SHALL last exactly FUSE_FRAMES edges, then enter FLAME with counter 0.
REQ-018 A FUSE slot whose cell is set in the current Flame_Map SHALL enter FLAME on the next edge (chain reaction).
REQ-019 FLAME SHALL last exactly FLAME_FRAMES edges, then return to IDLE, freeing slot and cell.
REQ-020 Flame pattern SHALL be: centre cell plus, per direction, up to FLAME_RANGE cells, stopping before a Wall cell.
REQ-021 A Tree cell SHALL be lit and SHALL stop propagation beyond it.
REQ-022 Left/right propagation SHALL NOT wrap across rows (col 0 and col 11 are boundaries); up/down SHALL stop at rows 0 and 11.
REQ-023 Flame_Map SHALL be the registered OR of all FLAME slots' patterns; Bomb_Map the registered OR of FUSE slots' cells.
REQ-024 Tree_Clear SHALL pulse for one frame, on FLAME entry, for each tree cell in that slot's pattern.
REQ-025 A cell SHALL never be set in both Bomb_Map and Flame_Map from the same slot.

Reset
REQ-026 On Reset all slots SHALL return to IDLE, counters 0; Bomb_Map, Flame_Map, Tree_Clear, Slot_Busy SHALL be all-zero on the next edge.
REQ-027 Reset mid-FUSE or mid-FLAME SHALL abort without emitting Tree_Clear.
REQ-028 Requests presented while Reset is high SHALL be ignored.

Structure
REQ-029 Shared package SHALL hold grid constants (12 columns, 12 rows, 144 cells), slot state enum, and cell index type.
REQ-030 Flame pattern generation SHALL be one combinational sub-module, flame_pattern (centre index, Wall_Map, Tree_Map -> 144-bit pattern).
REQ-031 Slots SHALL be generate-replicated; no per-slot hand copies.

Verification
REQ-032 Bomb_Index_1=66 one frame -> Bomb_Map[66]=1 next frame; after 120 frames Flame_Map bits 42,54,64,65,66,67,68,78,90 set for 30 frames, then clear.
REQ-033 Wall_Map[67]=1, bomb at 66 -> flame excludes 67 and 68; Tree_Map[54]=1 -> 54 lit, 42 not lit, Tree_Clear[54] pulses one frame.
REQ-034 Bomb at 13 (row 1, col 1), FLAME_RANGE=2 -> no bits at 11, 23, or row 0 beyond 1; no row wrap.
REQ-035 Bombs at 66 then 68 ten frames later -> 68 enters FLAME one frame after 66's flame covers it, not at its own fuse expiry.
REQ-036 Both inputs=66 same cycle -> one slot busy; five valid requests with NUM_SLOTS=4 -> fifth dropped, Slot_Busy=4'b1111.
REQ-037 Reset asserted during FLAME -> all outputs zero next edge, no further Tree_Clear pulse.

Source files
------------

// File: rtl/bomb_controller_pkg.sv
// Shared grid geometry, slot state encoding and cell helpers for the bomb controller.
package bomb_controller_pkg;
  localparam int GRID_COLS = 12;
  localparam int GRID_ROWS = 12;
  localparam int NUM_CELLS = GRID_COLS * GRID_ROWS;

  typedef logic [7:0]           cell_idx_t;
  typedef logic [NUM_CELLS-1:0] cell_map_t;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_FUSE  = 2'd1,
    SLOT_FLAME = 2'd2
  } slot_state_e;

  function automatic cell_map_t cell_onehot(input cell_idx_t idx);
    cell_onehot = cell_map_t'(1) << idx;
  endfunction
endpackage

// File: rtl/bomb_controller_flame_pattern.sv
// Cross-shaped flame footprint around one cell: walls stop the flame short,
// trees burn but absorb it, grid edges never wrap.
module flame_pattern
  import bomb_controller_pkg::*;
#(
  parameter int RANGE = 2
) (
  input  logic [7:0]   center,
  input  logic [143:0] wall_map,
  input  logic [143:0] tree_map,
  output logic [143:0] pattern
);
  int        row, col, nr, nc;
  logic      go;
  cell_idx_t idx;

  always_comb begin
    pattern = '0;
    row     = int'(center) / GRID_COLS;
    col     = int'(center) % GRID_COLS;
    nr      = 0;
    nc      = 0;
    go      = 1'b0;
    idx     = '0;
    if (int'(center) < NUM_CELLS) begin
      pattern[center] = 1'b1;
      for (int dir = 0; dir < 4; dir++) begin
        go = 1'b1;
        for (int d = 1; d <= RANGE; d++) begin
          case (dir)
            0:       begin nr = row - d; nc = col;     end
            1:       begin nr = row + d; nc = col;     end
            2:       begin nr = row;     nc = col - d; end
            default: begin nr = row;     nc = col + d; end
          endcase
          if (nr < 0 || nr >= GRID_ROWS || nc < 0 || nc >= GRID_COLS) go = 1'b0;
          if (go) begin
            idx = 8'(nr * GRID_COLS + nc);
            if (wall_map[idx]) go = 1'b0;
            else begin
              pattern[idx] = 1'b1;
              if (tree_map[idx]) go = 1'b0;
            end
          end
        end
      end
    end
  end
endmodule

// File: rtl/bomb_controller.sv
// Bomb slot pool: placement arbitration, per-slot fuse/flame FSMs with chain
// reactions, and registered bomb/flame/tree-clear maps.
module bomb_controller
  import bomb_controller_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int FUSE_FRAMES  = 120,
  parameter int FLAME_FRAMES = 30,
  parameter int FLAME_RANGE  = 2
) (
  input  logic                 Frame_Clk,
  input  logic                 Reset,
  input  logic [31:0]          Bomb_Index_1,
  input  logic [31:0]          Bomb_Index_2,
  input  logic [143:0]         Wall_Map,
  input  logic [143:0]         Tree_Map,
  output logic [143:0]         Bomb_Map,
  output logic [143:0]         Flame_Map,
  output logic [143:0]         Tree_Clear,
  output logic [NUM_SLOTS-1:0] Slot_Busy
);
  localparam int CNT_MAX = (FUSE_FRAMES > FLAME_FRAMES) ? FUSE_FRAMES : FLAME_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [NUM_SLOTS-1:0]                busy, load1, load2;
  logic [NUM_SLOTS-1:0][7:0]           slot_cell;
  logic [NUM_SLOTS-1:0][NUM_CELLS-1:0] bomb_bits, flame_bits, clear_bits;
  cell_map_t bomb_map_q, bomb_map_d, flame_map_q, flame_map_d, tree_clear_q, tree_clear_d;
  cell_idx_t idx1, idx2;
  logic      held1, held2, ok1, ok2, taken1, taken2;

  // Player 1 wins ties: it claims the lowest idle slot, player 2 the next one.
  always_comb begin
    idx1  = Bomb_Index_1[7:0];
    idx2  = Bomb_Index_2[7:0];
    held1 = 1'b0;
    held2 = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (busy[s] && slot_cell[s] == idx1) held1 = 1'b1;
      if (busy[s] && slot_cell[s] == idx2) held2 = 1'b1;
    end
    ok1 = (Bomb_Index_1 != 32'd0) && (Bomb_Index_1 < 32'(NUM_CELLS)) && !Wall_Map[idx1] && !held1;
    ok2 = (Bomb_Index_2 != 32'd0) && (Bomb_Index_2 < 32'(NUM_CELLS)) && !Wall_Map[idx2] && !held2
          && (Bomb_Index_2 != Bomb_Index_1);
    load1  = '0;
    load2  = '0;
    taken1 = 1'b0;
    taken2 = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!busy[s]) begin
        if (ok1 && !taken1) begin
          load1[s] = 1'b1;
          taken1   = 1'b1;
        end else if (ok2 && !taken2) begin
          load2[s] = 1'b1;
          taken2   = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    slot_state_e      state_q, state_d;
    cell_idx_t        cell_q, cell_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cell_map_t        pattern;

    flame_pattern #(.RANGE(FLAME_RANGE)) u_pat (
      .center   (cell_q),
      .wall_map (Wall_Map),
      .tree_map (Tree_Map),
      .pattern  (pattern)
    );

    always_comb begin
      state_d = state_q;
      cell_d  = cell_q;
      cnt_d   = cnt_q;
      case (state_q)
        SLOT_IDLE: begin
          if (load1[g]) begin
            state_d = SLOT_FUSE;
            cell_d  = idx1;
            cnt_d   = '0;
          end else if (load2[g]) begin
            state_d = SLOT_FUSE;
            cell_d  = idx2;
            cnt_d   = '0;
          end
        end
        SLOT_FUSE: begin
          // Any lit flame on our cell sets us off early.
          if (cnt_q == CNT_W'(FUSE_FRAMES - 1) || flame_map_q[cell_q]) begin
            state_d = SLOT_FLAME;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        SLOT_FLAME: begin
          if (cnt_q == CNT_W'(FLAME_FRAMES - 1)) begin
            state_d = SLOT_IDLE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        default: begin
          state_d = SLOT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge Frame_Clk) begin
      if (Reset) begin
        state_q <= SLOT_IDLE;
        cell_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cell_q  <= cell_d;
        cnt_q   <= cnt_d;
      end
    end

    assign busy[g]       = (state_q != SLOT_IDLE);
    assign slot_cell[g]  = cell_q;
    assign bomb_bits[g]  = (state_d == SLOT_FUSE) ? cell_onehot(cell_d) : '0;
    assign flame_bits[g] = (state_d == SLOT_FLAME) ? pattern : '0;
    assign clear_bits[g] = (state_q == SLOT_FUSE && state_d == SLOT_FLAME) ? (pattern & Tree_Map) : '0;
  end

  // Maps are built from next-state so they line up with the slot registers.
  always_comb begin
    bomb_map_d   = '0;
    flame_map_d  = '0;
    tree_clear_d = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      bomb_map_d   = bomb_map_d | bomb_bits[s];
      flame_map_d  = flame_map_d | flame_bits[s];
      tree_clear_d = tree_clear_d | clear_bits[s];
    end
  end

  always_ff @(posedge Frame_Clk) begin
    if (Reset) begin
      bomb_map_q   <= '0;
      flame_map_q  <= '0;
      tree_clear_q <= '0;
    end else begin
      bomb_map_q   <= bomb_map_d;
      flame_map_q  <= flame_map_d;
      tree_clear_q <= tree_clear_d;
    end
  end

  assign Bomb_Map   = bomb_map_q;
  assign Flame_Map  = flame_map_q;
  assign Tree_Clear = tree_clear_q;
  assign Slot_Busy  = busy;
endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller: fuse/flame timing, walls, trees, edges,
// chain reaction, arbitration and reset abort.
module tb_bomb_controller;
  logic         Frame_Clk = 1'b0;
  logic         Reset;
  logic [31:0]  Bomb_Index_1, Bomb_Index_2;
  logic [143:0] Wall_Map, Tree_Map;
  logic [143:0] Bomb_Map, Flame_Map, Tree_Clear;
  logic [3:0]   Slot_Busy;

  int total = 0;
  int bad   = 0;

  bomb_controller dut (
    .Frame_Clk    (Frame_Clk),
    .Reset        (Reset),
    .Bomb_Index_1 (Bomb_Index_1),
    .Bomb_Index_2 (Bomb_Index_2),
    .Wall_Map     (Wall_Map),
    .Tree_Map     (Tree_Map),
    .Bomb_Map     (Bomb_Map),
    .Flame_Map    (Flame_Map),
    .Tree_Clear   (Tree_Clear),
    .Slot_Busy    (Slot_Busy)
  );

  always #5 Frame_Clk = ~Frame_Clk;

  function automatic logic [143:0] bm(input int a);
    bm = 144'(1) << a;
  endfunction

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Frame_Clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [143:0] pat66, pat66_wt, pat68, pat13, seen;

  initial begin
    pat66    = bm(66) | bm(54) | bm(42) | bm(78) | bm(90) | bm(65) | bm(64) | bm(67) | bm(68);
    pat66_wt = bm(66) | bm(54) | bm(78) | bm(90) | bm(65) | bm(64);
    pat68    = bm(68) | bm(56) | bm(44) | bm(80) | bm(92) | bm(67) | bm(66) | bm(69) | bm(70);
    pat13    = bm(13) | bm(1)  | bm(12) | bm(14) | bm(15) | bm(25) | bm(37);

    // Reset with a request pending: it must be ignored.
    Reset = 1'b1; Bomb_Index_1 = 66; Bomb_Index_2 = 0; Wall_Map = '0; Tree_Map = '0;
    run(2);
    chk("rst_bomb", Bomb_Map, '0);
    chk("rst_busy", 144'(Slot_Busy), '0);
    Reset = 1'b0; Bomb_Index_1 = 0;
    step();
    chk("rst_flame", Flame_Map, '0);
    chk("rst_clear", Tree_Clear, '0);
    chk("rst_req_ignored", 144'(Slot_Busy), '0);

    // Basic fuse/flame timing at cell 66.
    Bomb_Index_1 = 66; step(); Bomb_Index_1 = 0;
    chk("a_bomb_set", Bomb_Map, bm(66));
    chk("a_busy", 144'(Slot_Busy), 144'(4'b0001));
    run(119);
    chk("a_fuse_end_bomb", Bomb_Map, bm(66));
    chk("a_fuse_end_flame", Flame_Map, '0);
    step();
    chk("a_flame_on", Flame_Map, pat66);
    chk("a_bomb_off", Bomb_Map, '0);
    run(29);
    chk("a_flame_last", Flame_Map, pat66);
    step();
    chk("a_flame_off", Flame_Map, '0);
    chk("a_idle", 144'(Slot_Busy), '0);

    // Wall at 67, tree at 54.
    Wall_Map = bm(67); Tree_Map = bm(54);
    Bomb_Index_1 = 66; step(); Bomb_Index_1 = 0;
    run(120);
    chk("b_flame_wt", Flame_Map, pat66_wt);
    chk("b_tree_clear", Tree_Clear, bm(54));
    step();
    chk("b_tree_pulse_end", Tree_Clear, '0);
    run(29);
    chk("b_idle", 144'(Slot_Busy), '0);

    // Near-corner cell 13: no wrap, no row -1.
    Wall_Map = '0; Tree_Map = '0;
    Bomb_Index_1 = 13; step(); Bomb_Index_1 = 0;
    run(120);
    chk("c_flame13", Flame_Map, pat13);
    run(30);
    chk("c_idle", 144'(Slot_Busy), '0);

    // Chain reaction: 68 placed 10 frames after 66.
    Bomb_Index_1 = 66; step(); Bomb_Index_1 = 0;
    run(9);
    Bomb_Index_1 = 68; step(); Bomb_Index_1 = 0;
    chk("d_bombs", Bomb_Map, bm(66) | bm(68));
    chk("d_busy", 144'(Slot_Busy), 144'(4'b0011));
    run(110);
    chk("d_flame66", Flame_Map, pat66);
    chk("d_bomb68", Bomb_Map, bm(68));
    step();
    chk("d_chain_flame", Flame_Map, pat66 | pat68);
    chk("d_chain_bomb", Bomb_Map, '0);
    run(29);
    chk("d_flame68_only", Flame_Map, pat68);
    step();
    chk("d_all_off", Flame_Map, '0);

    // Arbitration and invalid requests.
    Wall_Map = bm(67);
    Bomb_Index_1 = 144; Bomb_Index_2 = 67; step();
    chk("e_invalid", 144'(Slot_Busy), '0);
    Bomb_Index_1 = 66; Bomb_Index_2 = 66; step();
    chk("e_same_cell", 144'(Slot_Busy), 144'(4'b0001));
    Bomb_Index_1 = 66; Bomb_Index_2 = 20; step();
    chk("e_held_drop", 144'(Slot_Busy), 144'(4'b0011));
    Bomb_Index_1 = 30; Bomb_Index_2 = 40; step();
    Bomb_Index_1 = 50; Bomb_Index_2 = 0; step();
    Bomb_Index_1 = 0;
    chk("e_full_busy", 144'(Slot_Busy), 144'(4'b1111));
    chk("e_full_bombs", Bomb_Map, bm(66) | bm(20) | bm(30) | bm(40));
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("e_rst_busy", 144'(Slot_Busy), '0);
    chk("e_rst_bomb", Bomb_Map, '0);

    // Reset mid-flame aborts with no further tree clear.
    Wall_Map = '0; Tree_Map = bm(54);
    Bomb_Index_1 = 66; step(); Bomb_Index_1 = 0;
    run(120);
    chk("f_tree_clear", Tree_Clear, bm(54));
    run(5);
    Reset = 1'b1; step();
    chk("f_rst_flame", Flame_Map, '0);
    chk("f_rst_clear", Tree_Clear, '0);
    chk("f_rst_busy", 144'(Slot_Busy), '0);
    Reset = 1'b0;
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen = seen | Tree_Clear | Flame_Map | Bomb_Map;
    end
    chk("f_quiet_after", seen, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
